gate_chain_sequencer: RTL and testbench

GATE_CHAIN_SEQUENCER -- requirements
Module: gate_chain_sequencer

---
 rtl/gate_chain_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_gate_chain_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_chain_sequencer.sv
// gate_chain_sequencer
//
// Walks a chain of 2x2 complex gate matrices through an external 2x2 complex
// multiplier and keeps the running product acc = G_n * ... * G_1 * I. The
// newest gate is always applied on the left.
//
// Matrix ports are packed [row][col][re=0/im=1][18:0]. Each entry is a 19-bit
// signed fixed-point value with FRAC_BITS fractional bits.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-low reset
//   start       begin a chain (taken only in IDLE)
//   gate_count  number of gates in the chain (sampled together with start)
//   abort       terminate the current chain (LOAD/MUL/WAIT)
//   gate_in     next gate matrix
//   gate_valid  gate_in is valid
//   gate_ready  sequencer accepts gate_in this cycle
//   mul_a       left multiplier operand (captured gate)
//   mul_b       right multiplier operand (accumulator)
//   mul_start   one-cycle kick to the multiplier
//   mul_result  multiplier product
//   mul_done    multiplier completed flag
//   acc_out     accumulated product
//   busy        high outside IDLE
//   done        one-cycle pulse; acc_out is final
//   error       sticky timeout/abort flag, cleared by the next accepted start
module gate_chain_sequencer #(
   parameter int FRAC_BITS = 16,
   parameter int CNT_W     = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [CNT_W-1:0]              gate_count,
   input  logic                          abort,
   input  logic [1:0][1:0][1:0][18:0]    gate_in,
   input  logic                          gate_valid,
   output logic                          gate_ready,
   output logic [1:0][1:0][1:0][18:0]    mul_a,
   output logic [1:0][1:0][1:0][18:0]    mul_b,
   output logic                          mul_start,
   input  logic [1:0][1:0][1:0][18:0]    mul_result,
   input  logic                          mul_done,
   output logic [1:0][1:0][1:0][18:0]    acc_out,
   output logic                          busy,
   output logic                          done,
   output logic                          error
);

   localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [18:0] ONE = 19'(1 << FRAC_BITS);
   // Packed order runs [1][1][1] down to [0][0][0]: only the two real
   // diagonal entries carry ONE.
   localparam logic [1:0][1:0][1:0][18:0] IDENT = {19'd0, ONE, 95'd0, ONE};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MUL,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t                       state;
   state_t                       next_state;
   logic [1:0][1:0][1:0][18:0]   acc;
   logic [1:0][1:0][1:0][18:0]   g_reg;
   logic [CNT_W-1:0]             remaining;
   logic [WAIT_W-1:0]            wait_cnt;
   logic                         error_r;
   logic                         armed;

   logic                         accept_start;
   logic                         capture;
   logic                         take_result;
   logic                         set_error;
   logic                         inc_wait;

   assign mul_a   = g_reg;
   assign mul_b   = acc;
   assign acc_out = acc;
   assign error   = error_r;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output decode. Abort is checked first in every working
   // state, so it wins over gate acceptance, mul_done and the timeout.
   // gate_ready is dropped while abort is high so a handshake is never seen
   // without the gate actually being captured. start is only honoured once
   // armed has been set, which is one edge after reset deasserts.
   always_comb begin
      next_state   = state;
      gate_ready   = 1'b0;
      mul_start    = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      accept_start = 1'b0;
      capture      = 1'b0;
      take_result  = 1'b0;
      set_error    = 1'b0;
      inc_wait     = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start && armed) begin
               accept_start = 1'b1;
               next_state   = (gate_count == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            gate_ready = !abort;
            if (abort) begin
               set_error  = 1'b1;
               next_state = ST_DONE;
            end else if (gate_valid) begin
               capture    = 1'b1;
               next_state = ST_MUL;
            end
         end
         ST_MUL: begin
            mul_start = 1'b1;
            if (abort) begin
               set_error  = 1'b1;
               next_state = ST_DONE;
            end else begin
               next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               set_error  = 1'b1;
               next_state = ST_DONE;
            end else if (mul_done) begin
               take_result = 1'b1;
               next_state  = (remaining > CNT_W'(1)) ? ST_LOAD : ST_DONE;
            end else if (wait_cnt >= WAIT_W'(TIMEOUT)) begin
               set_error  = 1'b1;
               next_state = ST_DONE;
            end else begin
               inc_wait = 1'b1;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Datapath registers. acc only changes on an accepted start or a
   // completed multiply, and g_reg only on a gate handshake, so both
   // multiplier operands stay constant for the whole MUL/WAIT stretch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc       <= IDENT;
         g_reg     <= '0;
         remaining <= '0;
         wait_cnt  <= '0;
         error_r   <= 1'b0;
         armed     <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (accept_start) begin
            acc       <= IDENT;
            remaining <= gate_count;
            error_r   <= 1'b0;
         end
         if (capture) begin
            g_reg <= gate_in;
         end
         if (take_result) begin
            acc       <= mul_result;
            remaining <= remaining - CNT_W'(1);
         end
         if (set_error) begin
            error_r <= 1'b1;
         end
         if (state == ST_MUL) begin
            wait_cnt <= '0;
         end else if (inc_wait) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_gate_chain_sequencer.sv
// tb_gate_chain_sequencer
//
// Directed and randomized bench for gate_chain_sequencer. A behavioural
// 2x2 complex multiplier with programmable latency answers mul_start, and
// the expected accumulator is the plain matrix product of the gates sent.
module tb_gate_chain_sequencer;

   localparam int FRAC_BITS = 16;
   localparam int CNT_W     = 8;
   localparam int TIMEOUT   = 15;

   typedef logic [1:0][1:0][1:0][18:0] mat_t;

   logic             clk;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] gate_count;
   logic             abort;
   mat_t             gate_in;
   logic             gate_valid;
   logic             gate_ready;
   mat_t             mul_a;
   mat_t             mul_b;
   logic             mul_start;
   mat_t             mul_result;
   logic             mul_done;
   mat_t             acc_out;
   logic             busy;
   logic             done;
   logic             error;

   int   vectors    = 0;
   int   miscompares = 0;
   int   mul_lat    = 2;
   bit   mul_enable = 1'b1;
   int   mul_starts = 0;
   mat_t last_a;
   mat_t last_b;

   gate_chain_sequencer #(
      .FRAC_BITS (FRAC_BITS),
      .CNT_W     (CNT_W),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .gate_count (gate_count),
      .abort      (abort),
      .gate_in    (gate_in),
      .gate_valid (gate_valid),
      .gate_ready (gate_ready),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_start  (mul_start),
      .mul_result (mul_result),
      .mul_done   (mul_done),
      .acc_out    (acc_out),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic mat_t ident();
      mat_t m = '0;
      m[0][0][0] = 19'(1 << FRAC_BITS);
      m[1][1][0] = 19'(1 << FRAC_BITS);
      return m;
   endfunction

   function automatic mat_t pauli_x();
      mat_t m = '0;
      m[0][1][0] = 19'(1 << FRAC_BITS);
      m[1][0][0] = 19'(1 << FRAC_BITS);
      return m;
   endfunction

   function automatic mat_t rand_mat();
      mat_t m;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            for (int p = 0; p < 2; p++)
               m[r][c][p] = 19'($urandom);
      return m;
   endfunction

   // Fixed-point complex 2x2 product a*b, truncated to 19 bits.
   function automatic mat_t matmul(input mat_t a, input mat_t b);
      mat_t   c;
      longint re;
      longint im;
      longint ar, ai, br, bi;
      for (int r = 0; r < 2; r++) begin
         for (int col = 0; col < 2; col++) begin
            re = 0;
            im = 0;
            for (int k = 0; k < 2; k++) begin
               ar = longint'($signed(a[r][k][0]));
               ai = longint'($signed(a[r][k][1]));
               br = longint'($signed(b[k][col][0]));
               bi = longint'($signed(b[k][col][1]));
               re += ar * br - ai * bi;
               im += ar * bi + ai * br;
            end
            c[r][col][0] = 19'(re >>> FRAC_BITS);
            c[r][col][1] = 19'(im >>> FRAC_BITS);
         end
      end
      return c;
   endfunction

   // Behavioural multiplier: sees mul_start in the MUL cycle, raises
   // mul_done for one cycle mul_lat edges later.
   initial begin
      mat_t prod;
      mul_done   = 1'b0;
      mul_result = '0;
      forever begin
         @(negedge clk);
         if (reset && mul_start) begin
            mul_starts++;
            last_a = mul_a;
            last_b = mul_b;
            if (mul_enable) begin
               prod = matmul(mul_a, mul_b);
               @(posedge clk);
               repeat (mul_lat - 1) @(posedge clk);
               #1;
               if (reset) begin
                  mul_result = prod;
                  mul_done   = 1'b1;
                  @(posedge clk);
                  #1;
                  mul_done = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [151:0] obs, input logic [151:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Offer one gate and hold it until the handshake edge. While waiting,
   // start is toggled randomly to show it is ignored mid-chain.
   task automatic applyStimulus(input mat_t g, output int waited);
      waited     = 0;
      gate_in    = g;
      gate_valid = 1'b1;
      while (!gate_ready && waited < 64) begin
         start      = 1'($urandom_range(0, 1));
         gate_count = CNT_W'($urandom);
         tick();
         waited++;
      end
      start = 1'b0;
      if (!gate_ready) begin
         checkOutput("gate_ready_timeout", 1'b0, 1'b1);
      end else begin
         tick();
      end
      gate_valid = 1'b0;
      gate_in    = rand_mat();
   endtask

   task automatic start_chain(input int n);
      start      = 1'b1;
      gate_count = CNT_W'(n);
      tick();
      start      = 1'b0;
      gate_count = CNT_W'($urandom);
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 100) begin
         tick();
         cycles++;
      end
      if (!done) checkOutput("done_timeout", 1'b0, 1'b1);
   endtask

   task automatic run_random_chain(input int n, input bit gapmode);
      mat_t exp_acc = ident();
      mat_t g;
      int   base = mul_starts;
      int   gap;
      int   waited;
      int   cycles;
      start_chain(n);
      for (int i = 0; i < n; i++) begin
         g   = rand_mat();
         gap = gapmode ? $urandom_range(0, 3) : 0;
         repeat (gap) tick();
         applyStimulus(g, waited);
         if (i > 0 && gap == 0 && mul_lat == 2) checkOutput("gate_period", waited, 3);
         exp_acc = matmul(g, exp_acc);
      end
      wait_done(cycles);
      checkOutput("chain_acc", acc_out, exp_acc);
      checkOutput("chain_error", error, 1'b0);
      checkOutput("chain_mul_starts", mul_starts - base, n);
      tick();
      checkOutput("chain_done_once", done, 1'b0);
      checkOutput("chain_idle", busy, 1'b0);
   endtask

   initial begin
      mat_t g1, g2, exp_acc;
      int   base;
      int   waited;
      int   cycles;

      reset      = 1'b0;
      start      = 1'b0;
      gate_count = '0;
      abort      = 1'b0;
      gate_valid = 1'b0;
      gate_in    = '0;
      $display("[TB] reset state");
      tick();
      tick();
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_error", error, 1'b0);
      checkOutput("rst_ready", gate_ready, 1'b0);
      checkOutput("rst_mul_start", mul_start, 1'b0);
      checkOutput("rst_acc", acc_out, ident());
      checkOutput("rst_mul_a", mul_a, '0);

      $display("[TB] first start after reset, empty chain");
      start      = 1'b1;
      gate_count = '0;
      reset      = 1'b1;
      tick();
      checkOutput("first_edge_ignored", busy, 1'b0);
      tick();
      start = 1'b0;
      checkOutput("empty_done", done, 1'b1);
      checkOutput("empty_acc", acc_out, ident());
      checkOutput("empty_error", error, 1'b0);
      tick();
      checkOutput("empty_done_once", done, 1'b0);
      checkOutput("empty_idle", busy, 1'b0);

      $display("[TB] single Pauli-X");
      base = mul_starts;
      start_chain(1);
      checkOutput("x_busy", busy, 1'b1);
      checkOutput("x_ready", gate_ready, 1'b1);
      applyStimulus(pauli_x(), waited);
      checkOutput("x_mul_start", mul_start, 1'b1);
      checkOutput("x_mul_a", mul_a, pauli_x());
      checkOutput("x_mul_b", mul_b, ident());
      tick();
      checkOutput("x_mul_start_pulse", mul_start, 1'b0);
      wait_done(cycles);
      checkOutput("x_acc", acc_out, pauli_x());
      checkOutput("x_starts", mul_starts - base, 1);
      checkOutput("x_captured_a", last_a, pauli_x());
      tick();
      checkOutput("x_done_once", done, 1'b0);

      $display("[TB] X then X with a stalled gate_valid");
      base = mul_starts;
      start_chain(2);
      applyStimulus(pauli_x(), waited);
      cycles = 0;
      while (!gate_ready && cycles < 20) begin
         tick();
         cycles++;
      end
      repeat (3) begin
         checkOutput("xx_ready_held", gate_ready, 1'b1);
         tick();
      end
      checkOutput("xx_ready_still", gate_ready, 1'b1);
      applyStimulus(pauli_x(), waited);
      wait_done(cycles);
      checkOutput("xx_acc", acc_out, ident());
      checkOutput("xx_starts", mul_starts - base, 2);
      tick();

      $display("[TB] random chains");
      for (int c = 0; c < 6; c++) begin
         mul_lat = (c % 3) + 1;
         run_random_chain($urandom_range(1, 5), 1'(c % 2));
      end
      mul_lat = 2;

      $display("[TB] multiplier timeout");
      mul_enable = 1'b0;
      start_chain(1);
      applyStimulus(rand_mat(), waited);
      wait_done(cycles);
      checkOutput("to_cycles", cycles, TIMEOUT + 2);
      checkOutput("to_error", error, 1'b1);
      checkOutput("to_acc", acc_out, ident());
      mul_enable = 1'b1;
      start      = 1'b1;
      gate_count = '0;
      tick();
      checkOutput("to_start_in_done_ignored", done, 1'b0);
      checkOutput("to_error_sticky", error, 1'b1);
      tick();
      start = 1'b0;
      checkOutput("to_restart_done", done, 1'b1);
      checkOutput("to_error_cleared", error, 1'b0);
      tick();

      $display("[TB] abort with mul_done");
      g1 = rand_mat();
      g2 = rand_mat();
      exp_acc = matmul(g1, ident());
      start_chain(2);
      applyStimulus(g1, waited);
      applyStimulus(g2, waited);
      tick();
      tick();
      abort = 1'b1;
      #1;
      checkOutput("ab_mul_done_seen", mul_done, 1'b1);
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkOutput("ab_done", done, 1'b1);
      checkOutput("ab_error", error, 1'b1);
      checkOutput("ab_acc", acc_out, exp_acc);
      tick();
      checkOutput("ab_idle", busy, 1'b0);

      $display("[TB] abort beats gate acceptance");
      start_chain(1);
      gate_in    = rand_mat();
      gate_valid = 1'b1;
      abort      = 1'b1;
      tick();
      abort      = 1'b0;
      gate_valid = 1'b0;
      checkOutput("abl_done", done, 1'b1);
      checkOutput("abl_error", error, 1'b1);
      checkOutput("abl_no_capture", mul_a, g2);
      checkOutput("abl_acc", acc_out, ident());
      tick();

      $display("[TB] reset mid-chain");
      start_chain(3);
      applyStimulus(rand_mat(), waited);
      applyStimulus(rand_mat(), waited);
      tick();
      reset = 1'b0;
      #1;
      checkOutput("mr_busy", busy, 1'b0);
      checkOutput("mr_done", done, 1'b0);
      checkOutput("mr_error", error, 1'b0);
      checkOutput("mr_ready", gate_ready, 1'b0);
      checkOutput("mr_mul_start", mul_start, 1'b0);
      checkOutput("mr_mul_a", mul_a, '0);
      checkOutput("mr_acc", acc_out, ident());
      tick();
      tick();
      reset = 1'b1;
      tick();
      run_random_chain(1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
